hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It generates the per-latch enable and flush controls that the forwarding unit cannot resolve: load-use stalls, instruction/data memory waits, taken-branch/jump flushes and the halt freeze. It sits beside `forwarding_unit` in the datapath. It owns a small registered FSM (RUN / DWAIT / HALTED) and two saturating performance counters.

---
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_sat_counter.sv | 34 +++
 rtl/hazard_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard controller.
//   cpu_types_pkg         : regbits_t, the 5-bit register specifier used by the core.
//   hazard_unit_types_pkg : hzstate_t controller states and the default counter width.
package cpu_types_pkg;
    typedef logic [4:0] regbits_t;
endpackage

package hazard_unit_types_pkg;
    localparam int CNTW_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hzstate_t;
endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   CLK     : clock, rising edge
//   RST     : asynchronous active-high reset, clears the count
//   inc_i   : add one this cycle (ignored once the count is all-ones)
//   count_o : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core: latch enables and bubble
// flushes for load-use stalls, memory waits, taken-branch redirects and halt.
// Outputs are Mealy (state + current inputs); state and counters are registered.
// Ports:
//   CLK, RST                 : clock, asynchronous active-high reset
//   IDrs, IDrt, IDusesRt     : source registers of the instruction in ID
//   EXrd, EXdREN             : destination / load flag of the instruction in EX
//   MMdmemAccess, dhit, ihit : memory request in MEM and memory ready strobes
//   MMbranchTaken, MMhalt    : PC redirect and HALT in MEM
//   PCEN..MMWBen             : latch enables
//   IFIDflush..EXMMflush     : bubble inserts (take precedence over the enable)
//   halted                   : sticky halt indication
//   stallCycles, flushCount  : saturating performance counters
//
// state  | meaning
// RUN    | normal issue, priority rules evaluated each cycle
// DWAIT  | pipeline frozen waiting for dhit
// HALTED | HALT retired, everything frozen until reset
module hazard_unit
    import cpu_types_pkg::*;
    import hazard_unit_types_pkg::*;
#(
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  regbits_t        IDrs,
    input  regbits_t        IDrt,
    input  logic            IDusesRt,
    input  regbits_t        EXrd,
    input  logic            EXdREN,
    input  logic            MMdmemAccess,
    input  logic            dhit,
    input  logic            ihit,
    input  logic            MMbranchTaken,
    input  logic            MMhalt,
    output logic            PCEN,
    output logic            IFIDen,
    output logic            IDEXen,
    output logic            EXMMen,
    output logic            MMWBen,
    output logic            IFIDflush,
    output logic            IDEXflush,
    output logic            EXMMflush,
    output logic            halted,
    output logic [CNTW-1:0] stallCycles,
    output logic [CNTW-1:0] flushCount
);
    hzstate_t state_q;
    hzstate_t state_d;

    logic load_use;
    logic pc_en, ifid_en, idex_en, exmm_en, mmwb_en;
    logic ifid_fl, idex_fl, exmm_fl;
    logic flush_evt;
    logic stall_evt;

    assign load_use = EXdREN && (EXrd != '0) &&
                      ((EXrd == IDrs) || (IDusesRt && (EXrd == IDrt)));

    always_comb begin
        state_d   = state_q;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmm_en   = 1'b1;
        mmwb_en   = 1'b1;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        exmm_fl   = 1'b0;
        flush_evt = 1'b0;

        case (state_q)
            RUN, DWAIT: begin
                // In DWAIT the MEM request is still the one being waited on,
                // so only dhit matters there.
                if (!dhit && (MMdmemAccess || (state_q == DWAIT))) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                    exmm_en = 1'b0;
                    mmwb_en = 1'b0;
                    state_d = DWAIT;
                end else begin
                    state_d = RUN;
                    if (MMbranchTaken) begin
                        ifid_fl   = 1'b1;
                        idex_fl   = 1'b1;
                        exmm_fl   = 1'b1;
                        flush_evt = 1'b1;
                    end else if (load_use) begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                        idex_fl = 1'b1;
                    end else if (!ihit) begin
                        pc_en   = 1'b0;
                        ifid_fl = 1'b1;
                    end
                end
                // HALT only counts once it actually moves into WB.
                if (mmwb_en && MMhalt) begin
                    state_d = HALTED;
                end
            end
            default: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_en = 1'b0;
                exmm_en = 1'b0;
                mmwb_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset forces a full freeze regardless of state or inputs.
    assign PCEN      = pc_en   & ~RST;
    assign IFIDen    = ifid_en & ~RST;
    assign IDEXen    = idex_en & ~RST;
    assign EXMMen    = exmm_en & ~RST;
    assign MMWBen    = mmwb_en & ~RST;
    assign IFIDflush = ifid_fl & ~RST;
    assign IDEXflush = idex_fl & ~RST;
    assign EXMMflush = exmm_fl & ~RST;
    assign halted    = (state_q == HALTED);

    assign stall_evt = !pc_en && (state_q != HALTED);

    sat_counter #(.W(CNTW)) u_stall_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .inc_i   (stall_evt),
        .count_o (stallCycles)
    );

    sat_counter #(.W(CNTW)) u_flush_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .inc_i   (flush_evt),
        .count_o (flushCount)
    );
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
    logic       CLK;
    logic       RST;
    logic [4:0] IDrs, IDrt, EXrd;
    logic       IDusesRt, EXdREN, MMdmemAccess, dhit, ihit, MMbranchTaken, MMhalt;
    logic       PCEN, IFIDen, IDEXen, EXMMen, MMWBen;
    logic       IFIDflush, IDEXflush, EXMMflush, halted;
    logic [3:0] stallCycles, flushCount;

    logic [4:0] en_v;
    logic [2:0] fl_v;

    int checks   = 0;
    int failures = 0;

    assign en_v = {PCEN, IFIDen, IDEXen, EXMMen, MMWBen};
    assign fl_v = {IFIDflush, IDEXflush, EXMMflush};

    hazard_unit #(.CNTW(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IDrs          (IDrs),
        .IDrt          (IDrt),
        .IDusesRt      (IDusesRt),
        .EXrd          (EXrd),
        .EXdREN        (EXdREN),
        .MMdmemAccess  (MMdmemAccess),
        .dhit          (dhit),
        .ihit          (ihit),
        .MMbranchTaken (MMbranchTaken),
        .MMhalt        (MMhalt),
        .PCEN          (PCEN),
        .IFIDen        (IFIDen),
        .IDEXen        (IDEXen),
        .EXMMen        (EXMMen),
        .MMWBen        (MMWBen),
        .IFIDflush     (IFIDflush),
        .IDEXflush     (IDEXflush),
        .EXMMflush     (EXMMflush),
        .halted        (halted),
        .stallCycles   (stallCycles),
        .flushCount    (flushCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IDrs = 5'd0; IDrt = 5'd0; IDusesRt = 1'b0; EXrd = 5'd0; EXdREN = 1'b0;
        MMdmemAccess = 1'b0; dhit = 1'b0; ihit = 1'b1; MMbranchTaken = 1'b0; MMhalt = 1'b0;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        cyc(); cyc();
        chk("rst_en", 32'(en_v), 32'b00000);
        chk("rst_fl", 32'(fl_v), 32'b000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall", 32'(stallCycles), 32'd0);
        chk("rst_flushcnt", 32'(flushCount), 32'd0);

        RST = 1'b0;
        #2;
        chk("run_en", 32'(en_v), 32'b11111);
        chk("run_fl", 32'(fl_v), 32'b000);
        cyc();
        chk("run_stall", 32'(stallCycles), 32'd0);

        // load-use on rs
        EXdREN = 1'b1; EXrd = 5'd8; IDrs = 5'd8;
        #2;
        chk("lu_rs_en", 32'(en_v), 32'b00111);
        chk("lu_rs_fl", 32'(fl_v), 32'b010);
        cyc();
        chk("lu_rs_stall", 32'(stallCycles), 32'd1);
        idle();
        #2;
        chk("lu_after_en", 32'(en_v), 32'b11111);
        cyc();
        chk("lu_after_stall", 32'(stallCycles), 32'd1);

        // load to $0 never stalls
        EXdREN = 1'b1; EXrd = 5'd0; IDrs = 5'd0;
        #2;
        chk("lu_r0_en", 32'(en_v), 32'b11111);
        cyc();

        // load-use on rt, only when rt is read
        EXdREN = 1'b1; EXrd = 5'd5; IDrt = 5'd5; IDrs = 5'd3; IDusesRt = 1'b1;
        #2;
        chk("lu_rt_en", 32'(en_v), 32'b00111);
        cyc();
        chk("lu_rt_stall", 32'(stallCycles), 32'd2);
        IDusesRt = 1'b0;
        #2;
        chk("lu_rt_unused_en", 32'(en_v), 32'b11111);
        cyc();
        chk("lu_rt_unused_stall", 32'(stallCycles), 32'd2);

        // asynchronous reset mid-cycle
        idle();
        #3;
        RST = 1'b1;
        #1;
        chk("arst_stall", 32'(stallCycles), 32'd0);
        chk("arst_en", 32'(en_v), 32'b00000);
        cyc();
        RST = 1'b0;

        // dmem miss: request cycle, 3 DWAIT cycles, then release
        MMdmemAccess = 1'b1; dhit = 1'b0;
        #2;
        chk("dmiss_req_en", 32'(en_v), 32'b00000);
        chk("dmiss_req_fl", 32'(fl_v), 32'b000);
        cyc();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("dwait_en", 32'(en_v), 32'b00000);
            cyc();
        end
        dhit = 1'b1;
        #2;
        chk("dwait_release_en", 32'(en_v), 32'b11111);
        cyc();
        chk("dwait_stall", 32'(stallCycles), 32'd4);
        MMdmemAccess = 1'b0; dhit = 1'b0;
        #2;
        chk("dwait_back_run_en", 32'(en_v), 32'b11111);
        cyc();
        chk("dwait_back_run_stall", 32'(stallCycles), 32'd4);

        // branch beats load-use and imiss
        MMbranchTaken = 1'b1; EXdREN = 1'b1; EXrd = 5'd8; IDrs = 5'd8; ihit = 1'b0;
        #2;
        chk("br_en", 32'(en_v), 32'b11111);
        chk("br_fl", 32'(fl_v), 32'b111);
        cyc();
        chk("br_flushcnt", 32'(flushCount), 32'd1);
        chk("br_stall", 32'(stallCycles), 32'd4);

        // dmem miss beats branch; branch applied on release
        MMdmemAccess = 1'b1; dhit = 1'b0;
        #2;
        chk("br_dmiss_en", 32'(en_v), 32'b00000);
        chk("br_dmiss_fl", 32'(fl_v), 32'b000);
        cyc();
        #2;
        chk("br_dwait_fl", 32'(fl_v), 32'b000);
        cyc();
        dhit = 1'b1;
        #2;
        chk("br_release_en", 32'(en_v), 32'b11111);
        chk("br_release_fl", 32'(fl_v), 32'b111);
        cyc();
        chk("br_release_flushcnt", 32'(flushCount), 32'd2);
        chk("br_release_stall", 32'(stallCycles), 32'd6);

        // imiss and counter saturation
        idle();
        ihit = 1'b0;
        #2;
        chk("imiss_en", 32'(en_v), 32'b01111);
        chk("imiss_fl", 32'(fl_v), 32'b100);
        repeat (8) cyc();
        chk("sat_before", 32'(stallCycles), 32'd14);
        repeat (12) cyc();
        chk("sat_hold", 32'(stallCycles), 32'd15);

        // halt
        idle();
        MMdmemAccess = 1'b1; dhit = 1'b1; MMhalt = 1'b1;
        #2;
        chk("halt_issue_en", 32'(en_v), 32'b11111);
        chk("halt_issue_halted", 32'(halted), 32'd0);
        cyc();
        chk("halted_flag", 32'(halted), 32'd1);
        chk("halted_en", 32'(en_v), 32'b00000);
        MMhalt = 1'b0; MMbranchTaken = 1'b1; ihit = 1'b0; MMdmemAccess = 1'b0; dhit = 1'b0;
        EXdREN = 1'b1; EXrd = 5'd8; IDrs = 5'd8;
        #2;
        chk("halted_toggle_en", 32'(en_v), 32'b00000);
        chk("halted_toggle_fl", 32'(fl_v), 32'b000);
        cyc();
        chk("halted_sticky", 32'(halted), 32'd1);
        chk("halted_flushcnt", 32'(flushCount), 32'd2);
        #3;
        RST = 1'b1;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_en", 32'(en_v), 32'b00000);
        cyc();
        RST = 1'b0;
        idle();
        #2;
        chk("post_halt_en", 32'(en_v), 32'b11111);
        cyc();
        chk("post_halt_stall", 32'(stallCycles), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
